// File: rtl/axis_lb_pkg.sv
// Shared types for the AXI-Stream loopback FIFO: applied mode and input framing state.
package axis_lb_pkg;

  typedef enum logic [1:0] {
    LB_LOOPBACK = 2'd0,
    LB_DROP     = 2'd1,
    LB_HOLD     = 2'd2
  } lb_mode_e;

  typedef enum logic {
    IN_IDLE  = 1'b0,
    IN_FRAME = 1'b1
  } in_state_e;

  // Encoding 3 is treated as HOLD, the safe choice for an undefined request.
  function automatic lb_mode_e decode_mode(input logic [1:0] req);
    case (req)
      2'd0:    return LB_LOOPBACK;
      2'd1:    return LB_DROP;
      default: return LB_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through registered output; level counts the output register.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 73,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_mem_cnt;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic w_load;
  logic w_mem_empty;
  logic w_mem_rd;
  logic w_bypass;
  logic w_mem_wr;
  logic w_rd;

  // Output register refills whenever it is empty or being consumed; an empty memory lets writes bypass.
  assign w_mem_empty = (r_mem_cnt == '0);
  assign w_load      = !r_out_valid || i_rd_ready;
  assign w_mem_rd    = w_load && !w_mem_empty;
  assign w_bypass    = w_load && w_mem_empty && i_wr_en;
  assign w_mem_wr    = i_wr_en && !w_bypass;
  assign w_rd        = r_out_valid && i_rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_level     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_mem_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_mem_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_mem_cnt <= r_mem_cnt + LVL_W'(w_mem_wr) - LVL_W'(w_mem_rd);
      r_level   <= r_level + LVL_W'(i_wr_en) - LVL_W'(w_rd);
      if (w_mem_rd) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (w_bypass) begin
        r_out_data  <= i_wr_data;
        r_out_valid <= 1'b1;
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Storage needs no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = r_out_data;
  assign o_rd_valid = r_out_valid;
  assign o_level    = r_level;
  assign o_full     = (r_level == LVL_W'(DEPTH));

endmodule

// File: rtl/axis_loopback_fifo.sv
// AXI-Stream loopback: frame-safe mode switching (loopback/drop/hold), tready gating and frame counters
// in front of a FWFT FIFO.
module axis_loopback_fifo
  import axis_lb_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk156,
  input  logic                     reset,
  input  logic [1:0]               mode_req,
  output logic [1:0]               mode_act,
  input  logic [DATA_W-1:0]        tx_axis_tdata,
  input  logic [KEEP_W-1:0]        tx_axis_tkeep,
  input  logic                     tx_axis_tvalid,
  output logic                     tx_axis_tready,
  input  logic                     tx_axis_tlast,
  output logic [DATA_W-1:0]        rx_axis_tdata,
  output logic [KEEP_W-1:0]        rx_axis_tkeep,
  output logic                     rx_axis_tvalid,
  input  logic                     rx_axis_tready,
  output logic                     rx_axis_tlast,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         tx_frames,
  output logic [CNT_W-1:0]         rx_frames,
  output logic [CNT_W-1:0]         drop_frames
);

  localparam int unsigned FIFO_W = DATA_W + KEEP_W + 1;

  lb_mode_e         r_mode_act;
  in_state_e        r_state;
  logic [CNT_W-1:0] r_tx_frames;
  logic [CNT_W-1:0] r_rx_frames;
  logic [CNT_W-1:0] r_drop_frames;

  logic              w_full;
  logic              w_tready;
  logic              w_tx_acc;
  logic              w_fifo_wr;
  logic              w_rx_acc;
  logic              w_mode_upd;
  logic [FIFO_W-1:0] w_fifo_out;
  logic              w_fifo_valid;

  // Ready depends only on registered mode/level (and reset), never on tvalid.
  always_comb begin
    w_tready = 1'b0;
    if (!reset) begin
      case (r_mode_act)
        LB_LOOPBACK: w_tready = !w_full;
        LB_DROP:     w_tready = 1'b1;
        default:     w_tready = 1'b0;
      endcase
    end
  end

  assign w_tx_acc  = tx_axis_tvalid && w_tready;
  assign w_fifo_wr = w_tx_acc && (r_mode_act == LB_LOOPBACK);
  assign w_rx_acc  = w_fifo_valid && rx_axis_tready;

  // Mode may change between frames only: idle without a frame starting now, or on the closing beat.
  assign w_mode_upd = ((r_state == IN_IDLE) && !(w_tx_acc && !tx_axis_tlast)) ||
                      (w_tx_acc && tx_axis_tlast);

  always_ff @(posedge clk156) begin
    if (reset) begin
      r_state       <= IN_IDLE;
      r_mode_act    <= LB_LOOPBACK;
      r_tx_frames   <= '0;
      r_rx_frames   <= '0;
      r_drop_frames <= '0;
    end else begin
      if (w_tx_acc) begin
        if (tx_axis_tlast) r_state <= IN_IDLE;
        else               r_state <= IN_FRAME;
      end
      if (w_mode_upd) r_mode_act <= decode_mode(mode_req);
      if (w_fifo_wr && tx_axis_tlast)
        r_tx_frames <= r_tx_frames + CNT_W'(1);
      if (w_tx_acc && tx_axis_tlast && (r_mode_act == LB_DROP))
        r_drop_frames <= r_drop_frames + CNT_W'(1);
      if (w_rx_acc && w_fifo_out[0])
        r_rx_frames <= r_rx_frames + CNT_W'(1);
    end
  end

  axis_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk156),
    .reset      (reset),
    .i_wr_data  ({tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast}),
    .i_wr_en    (w_fifo_wr),
    .o_rd_data  (w_fifo_out),
    .o_rd_valid (w_fifo_valid),
    .i_rd_ready (rx_axis_tready),
    .o_full     (w_full),
    .o_level    (fifo_level)
  );

  assign tx_axis_tready = w_tready;
  assign mode_act       = r_mode_act;
  assign rx_axis_tdata  = w_fifo_out[FIFO_W-1 -: DATA_W];
  assign rx_axis_tkeep  = w_fifo_out[KEEP_W:1];
  assign rx_axis_tlast  = w_fifo_out[0];
  assign rx_axis_tvalid = w_fifo_valid;
  assign tx_frames      = r_tx_frames;
  assign rx_frames      = r_rx_frames;
  assign drop_frames    = r_drop_frames;

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Directed bench for axis_loopback_fifo (64b/16 deep) plus a randomised run on a 128b/4 deep instance.
`timescale 1ns/1ps
module tb_axis_loopback_fifo;

  localparam int unsigned DW  = 64;
  localparam int unsigned KW  = 8;
  localparam int unsigned DP  = 16;
  localparam int unsigned CW  = 32;
  localparam int unsigned DW2 = 128;
  localparam int unsigned KW2 = 16;
  localparam int unsigned DP2 = 4;
  localparam int NB2 = 4000;

  typedef logic [DW+KW:0]   beat_t;
  typedef logic [DW2+KW2:0] beat2_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]            mode_req, mode_act;
  logic [DW-1:0]         tx_tdata, rx_tdata;
  logic [KW-1:0]         tx_tkeep, rx_tkeep;
  logic                  tx_tvalid, tx_tready, tx_tlast, rx_tvalid, rx_tready, rx_tlast;
  logic [$clog2(DP):0]   fifo_level;
  logic [CW-1:0]         tx_frames, rx_frames, drop_frames;

  logic [1:0]            mode_req2, mode_act2;
  logic [DW2-1:0]        tx_tdata2, rx_tdata2;
  logic [KW2-1:0]        tx_tkeep2, rx_tkeep2;
  logic                  tx_tvalid2, tx_tready2, tx_tlast2, rx_tvalid2, rx_tready2, rx_tlast2;
  logic [$clog2(DP2):0]  fifo_level2;
  logic [CW-1:0]         tx_frames2, rx_frames2, drop_frames2;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t rx_q[$];
  beat_t exp_q[$];

  axis_loopback_fifo #(.DATA_W(DW), .KEEP_W(KW), .DEPTH(DP), .CNT_W(CW)) u_dut (
    .clk156(clk), .reset(reset), .mode_req(mode_req), .mode_act(mode_act),
    .tx_axis_tdata(tx_tdata), .tx_axis_tkeep(tx_tkeep), .tx_axis_tvalid(tx_tvalid),
    .tx_axis_tready(tx_tready), .tx_axis_tlast(tx_tlast),
    .rx_axis_tdata(rx_tdata), .rx_axis_tkeep(rx_tkeep), .rx_axis_tvalid(rx_tvalid),
    .rx_axis_tready(rx_tready), .rx_axis_tlast(rx_tlast),
    .fifo_level(fifo_level), .tx_frames(tx_frames), .rx_frames(rx_frames),
    .drop_frames(drop_frames)
  );

  axis_loopback_fifo #(.DATA_W(DW2), .KEEP_W(KW2), .DEPTH(DP2), .CNT_W(CW)) u_dut2 (
    .clk156(clk), .reset(reset), .mode_req(mode_req2), .mode_act(mode_act2),
    .tx_axis_tdata(tx_tdata2), .tx_axis_tkeep(tx_tkeep2), .tx_axis_tvalid(tx_tvalid2),
    .tx_axis_tready(tx_tready2), .tx_axis_tlast(tx_tlast2),
    .rx_axis_tdata(rx_tdata2), .rx_axis_tkeep(rx_tkeep2), .rx_axis_tvalid(rx_tvalid2),
    .rx_axis_tready(rx_tready2), .rx_axis_tlast(rx_tlast2),
    .fifo_level(fifo_level2), .tx_frames(tx_frames2), .rx_frames(rx_frames2),
    .drop_frames(drop_frames2)
  );

  // Record every beat delivered by the 64-bit instance.
  always @(posedge clk)
    if (!reset && rx_tvalid && rx_tready) rx_q.push_back({rx_tdata, rx_tkeep, rx_tlast});

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk_beat(input int i, input bit last);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    d = {16'hBEEF, 16'(i), 32'h1234_5678 ^ 32'(i)};
    k = last ? 8'h0F : 8'hFF;
    return {d, k, last};
  endfunction

  function automatic int q_mismatch();
    int m = 0;
    if (rx_q.size() != exp_q.size()) return -1;
    foreach (rx_q[i]) if (rx_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tx_tvalid = 1'b0; tx_tvalid2 = 1'b0;
    step();
    reset = 1'b0;
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic send_beat(input beat_t b, output bit ok, output int tries);
    tx_tdata = b[DW+KW:KW+1]; tx_tkeep = b[KW:1]; tx_tlast = b[0]; tx_tvalid = 1'b1;
    ok = 1'b0; tries = 0;
    while (!ok && tries < 100) begin
      @(negedge clk); ok = tx_tready; tries++;
      @(posedge clk); #1;
    end
    tx_tvalid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (fifo_level == '0 && !rx_tvalid) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_tvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", tx_tready); end
    step();
    reset = 1'b0; tx_tvalid = 1'b0;
    n_checks++; if (rx_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_tvalid: got %b want 0", rx_tvalid); end
    n_checks++; if ({rx_tdata, rx_tkeep, rx_tlast} !== '0) begin n_fail++; $display("FAIL rst_rx_payload: got %h want 0", {rx_tdata, rx_tkeep, rx_tlast}); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    n_checks++; if ({tx_frames, rx_frames, drop_frames} !== '0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", tx_frames, rx_frames, drop_frames); end
    n_checks++; if (mode_act !== 2'd0) begin n_fail++; $display("FAIL rst_mode_act: got %0d want 0", mode_act); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_loopback();
    bit ok, dok; int tries, total, bad; beat_t b;
    do_reset(); rx_tready = 1'b1; mode_req = 2'd0; total = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      b = mk_beat(i, (i % 4) == 3);
      send_beat(b, ok, tries); total += tries; if (!ok) bad++;
      exp_q.push_back(b);
      if (i == 0) begin
        n_checks++; if (rx_tvalid !== 1'b1 || {rx_tdata, rx_tkeep, rx_tlast} !== b) begin n_fail++; $display("FAIL lb_latency: got v=%b %h want v=1 %h", rx_tvalid, {rx_tdata, rx_tkeep, rx_tlast}, b); end
      end
    end
    wait_drain(dok);
    n_checks++; if (bad != 0 || !dok) begin n_fail++; $display("FAIL lb_handshake: got %0d stalls drained=%b want 0 stalls drained=1", bad, dok); end
    n_checks++; if (total != 12) begin n_fail++; $display("FAIL lb_throughput: got %0d cycles want 12", total); end
    n_checks++; if (q_mismatch() != 0) begin n_fail++; $display("FAIL lb_data: got %0d beats (%0d mismatches) want 12 exact", rx_q.size(), q_mismatch()); end
    n_checks++; if (tx_frames !== 32'd3 || rx_frames !== 32'd3) begin n_fail++; $display("FAIL lb_frames: got tx=%0d rx=%0d want 3/3", tx_frames, rx_frames); end
  endtask

  task automatic test_backpressure();
    bit ok, dok; int tries, bad; beat_t b;
    do_reset(); rx_tready = 1'b0; mode_req = 2'd0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      b = mk_beat(100 + i, 1'b0);
      send_beat(b, ok, tries); if (!ok) bad++;
      exp_q.push_back(b);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_fill: got %0d rejected want 0", bad); end
    b = mk_beat(116, 1'b0);
    tx_tdata = b[DW+KW:KW+1]; tx_tkeep = b[KW:1]; tx_tlast = b[0]; tx_tvalid = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_checks++; if (tx_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready: got %b want 0", tx_tready); end
    n_checks++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL bp_level: got %0d want 16", fifo_level); end
    n_checks++; if (rx_tvalid !== 1'b1 || {rx_tdata, rx_tkeep, rx_tlast} !== exp_q[0]) begin n_fail++; $display("FAIL bp_rx_stable: got v=%b %h want v=1 %h", rx_tvalid, {rx_tdata, rx_tkeep, rx_tlast}, exp_q[0]); end
    @(posedge clk); #1;
    rx_tready = 1'b1;
    for (int i = 16; i < 20; i++) begin
      b = mk_beat(100 + i, i == 19);
      send_beat(b, ok, tries); if (!ok) bad++;
      exp_q.push_back(b);
    end
    wait_drain(dok);
    n_checks++; if (bad != 0 || !dok || q_mismatch() != 0) begin n_fail++; $display("FAIL bp_data: got %0d beats bad=%0d drained=%b want 20 in order", rx_q.size(), bad, dok); end
    n_checks++; if (tx_frames !== 32'd1 || rx_frames !== 32'd1) begin n_fail++; $display("FAIL bp_frames: got tx=%0d rx=%0d want 1/1", tx_frames, rx_frames); end
  endtask

  task automatic test_drop();
    bit ok, dok; int tries, total, bad; beat_t b;
    do_reset(); rx_tready = 1'b1; mode_req = 2'd0; bad = 0; total = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) mode_req = 2'd1;
      b = mk_beat(200 + i, i == 4);
      send_beat(b, ok, tries); if (!ok) bad++;
      exp_q.push_back(b);
      if (i == 2) begin
        n_checks++; if (mode_act !== 2'd0) begin n_fail++; $display("FAIL drop_midframe_mode: got %0d want 0", mode_act); end
      end
    end
    n_checks++; if (mode_act !== 2'd1) begin n_fail++; $display("FAIL drop_mode_after_tlast: got %0d want 1", mode_act); end
    @(negedge clk);
    n_checks++; if (tx_tready !== 1'b1) begin n_fail++; $display("FAIL drop_tready: got %b want 1", tx_tready); end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      send_beat(mk_beat(300 + i, (i % 3) == 2), ok, tries); total += tries; if (!ok) bad++;
    end
    wait_drain(dok);
    n_checks++; if (total != 6 || bad != 0) begin n_fail++; $display("FAIL drop_accept: got %0d cycles bad=%0d want 6/0", total, bad); end
    n_checks++; if (drop_frames !== 32'd2) begin n_fail++; $display("FAIL drop_count: got %0d want 2", drop_frames); end
    n_checks++; if (!dok || q_mismatch() != 0) begin n_fail++; $display("FAIL drop_rx: got %0d beats want 5 (first frame only)", rx_q.size()); end
    n_checks++; if (tx_frames !== 32'd1 || rx_frames !== 32'd1) begin n_fail++; $display("FAIL drop_frames_other: got tx=%0d rx=%0d want 1/1", tx_frames, rx_frames); end
  endtask

  task automatic test_hold();
    bit ok, dok; int tries, acc; beat_t b;
    do_reset(); rx_tready = 1'b0; mode_req = 2'd0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      b = mk_beat(400 + i, i == 5);
      send_beat(b, ok, tries);
      exp_q.push_back(b);
    end
    mode_req = 2'd3;
    step();
    n_checks++; if (mode_act !== 2'd2) begin n_fail++; $display("FAIL hold_mode: got %0d want 2", mode_act); end
    b = mk_beat(499, 1'b1);
    tx_tdata = b[DW+KW:KW+1]; tx_tkeep = b[KW:1]; tx_tlast = b[0]; tx_tvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (fifo_level !== 5'd6) begin n_fail++; $display("FAIL hold_queued: got %0d want 6", fifo_level); end
    @(posedge clk); #1;
    rx_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (tx_tready) acc++;
      @(posedge clk); #1;
    end
    tx_tvalid = 1'b0;
    wait_drain(dok);
    n_checks++; if (acc != 0) begin n_fail++; $display("FAIL hold_tready: got %0d accepting cycles want 0", acc); end
    n_checks++; if (!dok || fifo_level !== '0) begin n_fail++; $display("FAIL hold_level: got %0d want 0", fifo_level); end
    n_checks++; if (q_mismatch() != 0) begin n_fail++; $display("FAIL hold_drain: got %0d beats want 6", rx_q.size()); end
    n_checks++; if (tx_frames !== 32'd1 || rx_frames !== 32'd1) begin n_fail++; $display("FAIL hold_frames: got tx=%0d rx=%0d want 1/1", tx_frames, rx_frames); end
  endtask

  task automatic test_reset_midframe();
    bit ok, dok; int tries; beat_t b;
    do_reset(); rx_tready = 1'b0; mode_req = 2'd0;
    for (int i = 0; i < 5; i++) send_beat(mk_beat(500 + i, i == 1), ok, tries);
    mode_req = 2'd1;
    step();
    n_checks++; if (fifo_level !== 5'd5 || tx_frames !== 32'd1 || mode_act !== 2'd0) begin n_fail++; $display("FAIL rm_setup: got lvl=%0d tx=%0d mode=%0d want 5/1/0", fifo_level, tx_frames, mode_act); end
    reset = 1'b1; tx_tvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_tready !== 1'b0) begin n_fail++; $display("FAIL rm_tready: got %b want 0", tx_tready); end
    @(posedge clk); #1;
    reset = 1'b0; tx_tvalid = 1'b0; mode_req = 2'd0;
    n_checks++; if (rx_tvalid !== 1'b0 || fifo_level !== '0) begin n_fail++; $display("FAIL rm_flush: got v=%b lvl=%0d want 0/0", rx_tvalid, fifo_level); end
    n_checks++; if (tx_frames !== '0 || mode_act !== 2'd0) begin n_fail++; $display("FAIL rm_state: got tx=%0d mode=%0d want 0/0", tx_frames, mode_act); end
    rx_q.delete(); exp_q.delete();
    rx_tready = 1'b1;
    b = mk_beat(600, 1'b1);
    send_beat(b, ok, tries); exp_q.push_back(b);
    wait_drain(dok);
    n_checks++; if (!dok || q_mismatch() != 0) begin n_fail++; $display("FAIL rm_no_survivor: got %0d beats want 1", rx_q.size()); end
  endtask

  task automatic test_random();
    beat2_t m_q[$]; beat2_t got_b, want_b;
    int sent, got, lvl_bad, exp_tx, exp_rx, cyc; bit acc;
    do_reset(); mode_req2 = 2'd0; rx_tready2 = 1'b0;
    sent = 0; got = 0; lvl_bad = 0; exp_tx = 0; exp_rx = 0; cyc = 0;
    while (got < NB2 && cyc < 40000) begin
      if (!tx_tvalid2 && sent < NB2 && $urandom_range(1) == 1) begin
        tx_tdata2 = {$urandom, $urandom, $urandom, $urandom};
        tx_tkeep2 = 16'($urandom);
        tx_tlast2 = ($urandom_range(3) == 0);
        tx_tvalid2 = 1'b1;
      end
      rx_tready2 = ($urandom_range(1) == 1);
      @(negedge clk);
      acc = tx_tvalid2 && tx_tready2;
      if (acc) begin
        m_q.push_back({tx_tdata2, tx_tkeep2, tx_tlast2}); sent++;
        if (tx_tlast2) exp_tx++;
      end
      if (rx_tvalid2 && rx_tready2) begin
        got_b = {rx_tdata2, rx_tkeep2, rx_tlast2};
        want_b = (m_q.size() > 0) ? m_q.pop_front() : 'x;
        n_checks++; if (got_b !== want_b) begin n_fail++; $display("FAIL rnd_beat%0d: got %h want %h", got, got_b, want_b); end
        got++;
        if (rx_tlast2) exp_rx++;
      end
      if (fifo_level2 > 3'd4) lvl_bad++;
      @(posedge clk); #1;
      cyc++;
      if (acc) tx_tvalid2 = 1'b0;
    end
    rx_tready2 = 1'b0;
    @(negedge clk);
    n_checks++; if (got != NB2) begin n_fail++; $display("FAIL rnd_count: got %0d beats want %0d", got, NB2); end
    n_checks++; if (lvl_bad != 0) begin n_fail++; $display("FAIL rnd_level: got %0d cycles above 4 want 0", lvl_bad); end
    n_checks++; if (tx_frames2 !== CW'(exp_tx) || rx_frames2 !== CW'(exp_rx)) begin n_fail++; $display("FAIL rnd_frames: got tx=%0d rx=%0d want %0d/%0d", tx_frames2, rx_frames2, exp_tx, exp_rx); end
    n_checks++; if (drop_frames2 !== '0 || mode_act2 !== 2'd0) begin n_fail++; $display("FAIL rnd_mode: got drop=%0d mode=%0d want 0/0", drop_frames2, mode_act2); end
  endtask

  initial begin
    reset = 1'b1; mode_req = 2'd0; mode_req2 = 2'd0;
    tx_tdata = '0; tx_tkeep = '0; tx_tvalid = 1'b0; tx_tlast = 1'b0; rx_tready = 1'b0;
    tx_tdata2 = '0; tx_tkeep2 = '0; tx_tvalid2 = 1'b0; tx_tlast2 = 1'b0; rx_tready2 = 1'b0;
    test_reset();
    test_loopback();
    test_backpressure();
    test_drop();
    test_hold();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
